// File: rtl/weights_ram_loader_pkg.sv
// Shared constants and FSM encoding for the weights memory, its run-time loader
// and the layer controllers that read from it.
package weights_ram_loader_pkg;

    localparam int N      = 8;
    localparam int Q      = 7;
    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int CSUM_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    // A session must load at least one word and cannot overrun the RAM.
    function automatic logic len_is_legal(input logic [AW:0] len);
        return (len != '0) && (len <= (AW+1)'(DEPTH));
    endfunction

endpackage

// File: rtl/weights_dpram.sv
// Simple dual-port weights RAM: rising-edge write port, falling-edge registered
// read port, so a word written on a rising edge is readable half a cycle later.
module weights_dpram #(
    parameter int W     = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weights_ram_loader.sv
// Run-time writer for the weights memory: streams signed words over valid/ready
// into the RAM sequentially and keeps a checksum for host-side verification.
module weights_ram_loader
    import weights_ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW:0]       wr_len,
    input  logic [N-1:0]      s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CSUM_W-1:0] csum,
    input  logic [AW-1:0]     rd_addr,
    output logic [N-1:0]      rd_data
);

    load_state_t   state;
    load_state_t   state_next;
    logic [AW-1:0] ptr;
    logic [AW:0]   remaining;
    logic          accept;

    assign accept = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake and status outputs come straight from the registered state.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && len_is_legal(wr_len)) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && (remaining == (AW+1)'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pointer wraps naturally at DEPTH; the final word moves us out of LOAD,
    // so the wrapped pointer is never used for a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
            csum      <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_is_legal(wr_len)) begin
                            remaining <= wr_len;
                            ptr       <= '0;
                            csum      <= '0;
                            err       <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        ptr       <= ptr + AW'(1);
                        remaining <= remaining - (AW+1)'(1);
                        csum      <= csum + {{(CSUM_W-N){1'b0}}, s_data};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    weights_dpram #(
        .W     (N),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (ptr),
        .wdata (s_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_weights_ram_loader.sv
// Scoreboard bench for weights_ram_loader: stimulus queues expected session
// results and read data, a monitor compares them when the DUT presents them.
module tb_weights_ram_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  wr_len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] csum;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;

    typedef struct {
        logic [15:0] csum;
        int          count;
    } done_exp_t;

    done_exp_t   done_q[$];
    logic [7:0]  rd_q[$];
    logic        rd_req;
    int          xfer_cnt;
    logic [15:0] exp_csum;
    int          tests_run;
    int          tests_failed;

    weights_ram_loader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .wr_len  (wr_len),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .csum    (csum),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called in the posedge+1 phase; returns in the posedge+1 phase after the transfer edge.
    task automatic applyStimulus(input logic [7:0] data);
        logic rdy;
        logic ok;
        s_valid = 1'b1;
        s_data  = data;
        ok      = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_csum = exp_csum + {8'h00, data};
        end else begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: word %0h not accepted, expected within 64 cycles", data);
        end
    endtask

    task automatic startSession(input int len);
        @(posedge clk);
        #1;
        start  = 1'b1;
        wr_len = 9'(len);
        @(posedge clk);
        #1;
        start  = 1'b0;
        if (len >= 1 && len <= 256) begin
            exp_csum = 16'h0000;
        end
    endtask

    task automatic finishSession(input int count);
        done_exp_t e;
        s_valid = 1'b0;
        e.csum  = exp_csum;
        e.count = count;
        done_q.push_back(e);
        @(negedge clk);
        #1;
        checkOutput("done_pulse", {31'd0, done}, 32'd1);
        checkOutput("busy_in_done", {31'd0, busy}, 32'd1);
        checkOutput("s_ready_in_done", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("busy_back_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic check_busy);
        s_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (check_busy) checkOutput("busy_during_gap", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic readWord(input logic [7:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        rd_q.push_back(exp);
        rd_req = 1'b1;
        @(negedge clk);
        #2;
        rd_req = 1'b0;
    endtask

    // Monitor: checks session results on done and read data on requested falling edges.
    initial begin
        done_exp_t e;
        logic [7:0] r;
        xfer_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_done: done=1, expected no session end at %0t", $time);
                end else begin
                    e = done_q.pop_front();
                    checkOutput("session_csum", {16'd0, csum}, {16'd0, e.csum});
                    checkOutput("session_word_count", xfer_cnt, e.count);
                end
            end
            if (rd_req === 1'b1) begin
                if (rd_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL read_queue_empty: rd_data=%0h with no expectation", rd_data);
                end else begin
                    r = rd_q.pop_front();
                    checkOutput($sformatf("rd_data[%0d]", rd_addr), {24'd0, rd_data}, {24'd0, r});
                end
            end
            if (busy !== 1'b1) xfer_cnt = 0;
            else if (s_valid === 1'b1 && s_ready === 1'b1) xfer_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_csum     = 16'h0000;
        rst_n        = 1'b0;
        start        = 1'b0;
        wr_len       = 9'd0;
        s_data       = 8'h00;
        s_valid      = 1'b0;
        rd_addr      = 8'h00;
        rd_req       = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_s_ready", {31'd0, s_ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        checkOutput("reset_csum", {16'd0, csum}, 32'd0);
        checkOutput("reset_rd_data", {24'd0, rd_data}, 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h3C;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("idle_s_ready", {31'd0, s_ready}, 32'd0);
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        end
        s_valid = 1'b0;

        // Basic load of four words back-to-back
        startSession(4);
        applyStimulus(8'h01);
        applyStimulus(8'h7F);
        applyStimulus(8'h80);
        applyStimulus(8'hFF);
        finishSession(4);
        checkOutput("basic_csum", {16'd0, csum}, 32'h01FF);
        readWord(8'd0, 8'h01);
        readWord(8'd1, 8'h7F);
        readWord(8'd2, 8'h80);
        readWord(8'd3, 8'hFF);

        // Valid without start must not write
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        readWord(8'd0, 8'h01);

        // Back-pressure: valid pattern 1,0,0,1,0,1
        startSession(3);
        applyStimulus(8'h11);
        idleCycles(2, 1'b1);
        applyStimulus(8'h22);
        idleCycles(1, 1'b1);
        applyStimulus(8'h33);
        finishSession(3);
        readWord(8'd0, 8'h11);
        readWord(8'd1, 8'h22);
        readWord(8'd2, 8'h33);
        readWord(8'd3, 8'hFF);

        // Full depth with pointer wrap
        @(posedge clk);
        #1;
        startSession(256);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'(i));
        end
        finishSession(256);
        checkOutput("full_csum", {16'd0, csum}, 32'h7F80);
        readWord(8'd255, 8'hFF);
        readWord(8'd0, 8'h00);
        readWord(8'd128, 8'h80);

        // Illegal lengths
        @(posedge clk);
        #1;
        startSession(0);
        checkOutput("len0_err", {31'd0, err}, 32'd1);
        checkOutput("len0_busy", {31'd0, busy}, 32'd0);
        checkOutput("len0_s_ready", {31'd0, s_ready}, 32'd0);
        checkOutput("len0_csum_kept", {16'd0, csum}, 32'h7F80);
        startSession(257);
        checkOutput("len257_err", {31'd0, err}, 32'd1);
        checkOutput("len257_busy", {31'd0, busy}, 32'd0);
        startSession(2);
        checkOutput("len2_err_cleared", {31'd0, err}, 32'd0);
        checkOutput("len2_busy", {31'd0, busy}, 32'd1);
        checkOutput("len2_csum_cleared", {16'd0, csum}, 32'd0);
        applyStimulus(8'h5A);
        applyStimulus(8'hC3);
        finishSession(2);
        checkOutput("len2_csum", {16'd0, csum}, 32'h011D);

        // Write-then-read collision, then reset mid-load
        @(posedge clk);
        #1;
        startSession(10);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'hA0 + 8'(k));
        end
        rd_addr = 8'd5;
        applyStimulus(8'hA5);
        s_valid = 1'b0;
        readWord(8'd5, 8'hA5);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_s_ready", {31'd0, s_ready}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        checkOutput("midreset_csum", {16'd0, csum}, 32'd0);
        checkOutput("midreset_rd_data", {24'd0, rd_data}, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("after_reset_err", {31'd0, err}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            readWord(8'(k), 8'hA0 + 8'(k));
        end
        readWord(8'd6, 8'h06);
        repeat (5) @(negedge clk);
        #2;

        tests_run++;
        if (done_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL missed_done: %0d sessions never signalled done, expected 0", done_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/weights_ram_loader.md
Name: weights_ram_loader

Overview:
- Writer side of the weights memory: accepts a stream of N-bit signed weight words over a valid/ready handshake and writes them sequentially into an internal 256-entry RAM.
- The RAM's read port matches the existing weights memory timing: address in, registered output updated on the falling edge. The layer datapath can therefore read weights loaded at run time instead of from a fixed image.
- Reports busy, done and error status, plus a running checksum for host-side integrity checking.

Parameters:
N, 8, weight word width in bits (signed)
Q, 7, fractional bits of the weight format; carried for interface consistency, no arithmetic use
DEPTH, 256, number of RAM entries
AW, 8, address width; requires DEPTH == 2**AW

Ports:
clk  input  1  single system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a load session; sampled only in IDLE
wr_len  input  AW+1  number of words to load (valid range 1..DEPTH); latched on an accepted start
s_data  input  N  weight word to write (signed)
s_valid  input  1  s_data is valid
s_ready  output  1  loader accepts a word this cycle
busy  output  1  a load session is in progress
done  output  1  one-cycle pulse after the last word is written
err  output  1  sticky flag: start issued with an illegal wr_len
csum  output  16  modulo-2^16 sum of accepted words, each zero-extended from N bits
rd_addr  input  AW  read address
rd_data  output  N  registered read data (signed)

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE; s_ready=0, busy=0, done=0, err=0, csum=0, rd_data=0, write pointer=0. RAM contents are not cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - s_ready=0, busy=0.
  - start with 1<=wr_len<=DEPTH: latch wr_len into the remaining-word counter, clear the pointer and csum, clear err, go to LOAD.
  - start with wr_len==0 or wr_len>DEPTH: set err=1, stay in IDLE, leave csum unchanged.
- LOAD:
  - s_ready=1, busy=1.
  - Handshake: a word transfers on any rising edge where s_valid&&s_ready is true.
  - On each transfer: mem[ptr]<=s_data, ptr<=ptr+1, remaining<=remaining-1, csum<=csum+{0,s_data}.
  - The transfer that brings remaining from 1 to 0 moves the FSM to DONE. s_ready is registered low in DONE, so no extra word is accepted.
  - s_valid low: hold state; no timeout.
  - start pulses in LOAD or DONE are ignored.
- DONE: done=1 for exactly one cycle, busy=1, s_ready=0; next state is IDLE.
- Latency:
  - First word can transfer on the cycle after start.
  - Back-to-back transfers sustain one word per cycle.
  - done asserts on the cycle after the final transfer.
- Pointer wrap: with wr_len==DEPTH the pointer wraps from DEPTH-1 to 0 after the last word. No write occurs after the wrap.
- Read port:
  - rd_data <= mem[rd_addr] on every falling edge of clk, regardless of FSM state.
  - A word written at a rising edge is visible at the immediately following falling edge if rd_addr matches, i.e. same-cycle write-then-read returns the new data.
- Memory mapping: RAM is inferred as block RAM, one write port on posedge and one read port on negedge.
- Reset mid-LOAD: session aborts immediately. Words already written stay in RAM. done does not pulse. After reset release the block is in IDLE and requires a new start.
- csum wraps modulo 2^16. No saturation.

Decomposition:
- Shared package: FSM state encoding (IDLE, LOAD, DONE) and the constants N, Q, DEPTH, AW, reused by the weights memory and by the layer controllers.
- One sub-module is natural: weights_dpram, a simple dual-port RAM with posedge write and negedge registered read, DEPTH x N.
- The FSM, counters and checksum live in the top module.

Test Plan:
- Reset then idle: hold rst_n low, then release; check s_ready=0, busy=0, done=0, err=0, csum=0, rd_data=0. Then drive s_valid=1 with no start; check that no write occurs.
- Basic load:
  - Stimulus: start with wr_len=4, stream 8'h01, 8'h7F, 8'h80, 8'hFF back-to-back.
  - Response: done pulses once, on the cycle after the 4th transfer. csum=16'h01FF. Reading rd_addr 0..3 returns 1, 127, -128, -1.
- Back-pressure: start with wr_len=3, toggle s_valid 1,0,0,1,0,1. Check exactly 3 writes to addresses 0..2 and busy held high throughout.
- Full depth with wrap:
  - Stimulus: start with wr_len=256, stream data=addr[7:0].
  - Response: done fires after the 256th transfer. csum=16'h7F80. mem[255]=8'hFF and mem[0]=0, i.e. mem[0] is not overwritten.
- Illegal length: start with wr_len=0 -> err=1, state stays IDLE. start with wr_len=257 -> err stays 1. A following start with wr_len=2 clears err.
- Mid-load reset and read collision:
  - Write then read: rd_addr=5 while word 5 (8'hA5) transfers; rd_data=8'hA5 at the following falling edge.
  - Reset mid-load: assert rst_n low after 6 of 10 words; done never pulses and mem[0..5] is retained.
